// File: rtl/instr_encoder_if.sv
// rtl/instr_encoder_if.sv - Field-set handshake and memory-write bus of the RV32I program loader
//
// Signals (master = host/loader driver, slave = instr_encoder):
//   clr                      host -> encoder  synchronous clear of pointer, count, state, err
//   in_valid / in_ready      field-set handshake
//   opcode rd rs1 rs2        instruction fields
//   funct3 funct7 imm
//   mem_we mem_addr          instruction-memory write port
//   mem_wdata
//   count full err           status

interface instr_encoder_if #(
  parameter int ADDR_W = 8
);
  logic              clr;
  logic              in_valid;
  logic              in_ready;
  logic [6:0]        opcode;
  logic [4:0]        rd;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic [31:0]       imm;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              err;

  modport master (
    output clr, in_valid, opcode, rd, rs1, rs2, funct3, funct7, imm,
    input  in_ready, mem_we, mem_addr, mem_wdata, count, full, err
  );

  modport slave (
    input  clr, in_valid, opcode, rd, rs1, rs2, funct3, funct7, imm,
    output in_ready, mem_we, mem_addr, mem_wdata, count, full, err
  );
endinterface

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - Packs RV32I fields into instruction words and writes them sequentially to instruction memory
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   instr_encoder_if.slave (clr, field-set handshake, memory write port, count/full/err)
// Parameters:
//   ADDR_W     instruction-memory word-address width (capacity 2**ADDR_W words)
//   BASE_ADDR  first write address after reset or clear
// Optional feature macro:
//   ENCODER_CHECK_EN  flags unknown opcodes and odd B/J offsets as sticky err instead of writing

module instr_encoder #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic             clk,
  input  logic             rst,
  instr_encoder_if.slave   bus
);

  localparam logic [ADDR_W-1:0] BASE = BASE_ADDR[ADDR_W-1:0];
  localparam logic [ADDR_W:0]   CAP  = {1'b1, {ADDR_W{1'b0}}};

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_IMM  = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_SYS  = 7'b1110011;
  localparam logic [6:0] OP_S    = 7'b0100011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_AUI  = 7'b0010111;
  localparam logic [6:0] OP_J    = 7'b1101111;

  typedef enum logic [1:0] {IDLE, ENC, WR} state_t;

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W:0]   cnt;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;

  // Field set captured at the handshake so the host may change inputs afterwards.
  logic [6:0]  l_op;
  logic [4:0]  l_rd, l_rs1, l_rs2;
  logic [2:0]  l_f3;
  logic [6:0]  l_f7;
  logic [31:0] l_imm;

  logic [31:0] word;
  logic        enc_err;
  logic        full_w;

  always_comb begin
    word    = {l_imm[24:0], l_op};
    enc_err = 1'b1;
    case (l_op)
      OP_R: begin
        word    = {l_f7, l_rs2, l_rs1, l_f3, l_rd, l_op};
        enc_err = 1'b0;
      end
      OP_IMM: begin
        // Shift-immediates carry funct7 in the upper bits and a 5-bit shamt.
        if (l_f3 == 3'b001 || l_f3 == 3'b101)
          word = {l_f7, l_imm[4:0], l_rs1, l_f3, l_rd, l_op};
        else
          word = {l_imm[11:0], l_rs1, l_f3, l_rd, l_op};
        enc_err = 1'b0;
      end
      OP_LD, OP_JALR, OP_SYS: begin
        word    = {l_imm[11:0], l_rs1, l_f3, l_rd, l_op};
        enc_err = 1'b0;
      end
      OP_S: begin
        word    = {l_imm[11:5], l_rs2, l_rs1, l_f3, l_imm[4:0], l_op};
        enc_err = 1'b0;
      end
      OP_B: begin
        word    = {l_imm[12], l_imm[10:5], l_rs2, l_rs1, l_f3, l_imm[4:1], l_imm[11], l_op};
        enc_err = l_imm[0];
      end
      OP_LUI, OP_AUI: begin
        word    = {l_imm[31:12], l_rd, l_op};
        enc_err = 1'b0;
      end
      OP_J: begin
        word    = {l_imm[20], l_imm[10:1], l_imm[11], l_imm[19:12], l_rd, l_op};
        enc_err = l_imm[0];
      end
      default: begin
        word    = {l_imm[24:0], l_op};
        enc_err = 1'b1;
      end
    endcase
  end

  assign full_w = (cnt == CAP);

`ifdef ENCODER_CHECK_EN
  logic err_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= BASE;
      cnt     <= '0;
      we_q    <= 1'b0;
      addr_q  <= BASE;
      wdata_q <= '0;
      l_op    <= '0;
      l_rd    <= '0;
      l_rs1   <= '0;
      l_rs2   <= '0;
      l_f3    <= '0;
      l_f7    <= '0;
      l_imm   <= '0;
`ifdef ENCODER_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else if (bus.clr) begin
      // Clear drops any in-flight instruction, including one being accepted this edge.
      state <= IDLE;
      ptr   <= BASE;
      cnt   <= '0;
      we_q  <= 1'b0;
`ifdef ENCODER_CHECK_EN
      err_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          we_q <= 1'b0;
          if (bus.in_valid && !full_w) begin
            l_op  <= bus.opcode;
            l_rd  <= bus.rd;
            l_rs1 <= bus.rs1;
            l_rs2 <= bus.rs2;
            l_f3  <= bus.funct3;
            l_f7  <= bus.funct7;
            l_imm <= bus.imm;
            state <= ENC;
          end
        end
        ENC: begin
`ifdef ENCODER_CHECK_EN
          if (enc_err) begin
            err_q <= 1'b1;
            state <= IDLE;
          end else begin
            wdata_q <= word;
            addr_q  <= ptr;
            we_q    <= 1'b1;
            state   <= WR;
          end
`else
          wdata_q <= word;
          addr_q  <= ptr;
          we_q    <= 1'b1;
          state   <= WR;
`endif
        end
        WR: begin
          we_q  <= 1'b0;
          ptr   <= ptr + 1'b1;
          if (!full_w)
            cnt <= cnt + 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE) && !full_w;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.count     = cnt;
  assign bus.full      = full_w;
`ifdef ENCODER_CHECK_EN
  assign bus.err       = err_q;
`else
  assign bus.err       = 1'b0;
  logic unused_enc_err;
  assign unused_enc_err = enc_err;
`endif

endmodule
